// File: rtl/dram_bridge_pkg.sv
// rtl/dram_bridge_pkg.sv - shared address map and display constants for dram_bridge
package dram_bridge_pkg;

   localparam logic [31:0] DIGITS_ADDR = 32'hFFFF_F000;
   localparam logic [31:0] LED_ADDR    = 32'hFFFF_F060;
   localparam logic [31:0] SW_ADDR     = 32'hFFFF_F070;

   localparam int SEG_W     = 7;
   localparam int DIGIT_CNT = 8;
   localparam int IDX_W     = 3;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_DRAM,
      SEL_DIGITS,
      SEL_LED,
      SEL_SW
   } sel_e;

endpackage

// File: rtl/dram_bridge_seg_decode.sv
// rtl/dram_bridge_seg_decode.sv - hex nibble to active-low {g..a} segment pattern
module seg_decode
   import dram_bridge_pkg::*;
(
   input  logic [3:0]       nib_i,
   output logic [SEG_W-1:0] seg_o
);

   always_comb begin
      seg_o = 7'h7F;
      case (nib_i)
         4'h0: seg_o = 7'h40;
         4'h1: seg_o = 7'h79;
         4'h2: seg_o = 7'h24;
         4'h3: seg_o = 7'h30;
         4'h4: seg_o = 7'h19;
         4'h5: seg_o = 7'h12;
         4'h6: seg_o = 7'h02;
         4'h7: seg_o = 7'h78;
         4'h8: seg_o = 7'h00;
         4'h9: seg_o = 7'h10;
         4'hA: seg_o = 7'h08;
         4'hB: seg_o = 7'h03;
         4'hC: seg_o = 7'h46;
         4'hD: seg_o = 7'h21;
         4'hE: seg_o = 7'h06;
         4'hF: seg_o = 7'h0E;
         default: seg_o = 7'h7F;
      endcase
   end

endmodule

// File: rtl/dram_bridge.sv
// rtl/dram_bridge.sv - CPU data bus bridge: DRAM, LED/DIGITS registers, switch input, 7-seg scan
module dram_bridge
   import dram_bridge_pkg::*;
#(
   parameter int DRAM_WORDS = 4096,
   parameter int SCAN_DIV   = 20000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic        cpu_we,
   output logic [31:0] cpu_rdata,
   input  logic [23:0] sw,
   output logic [23:0] led,
   output logic [7:0]  seg_en,
   output logic [7:0]  seg_seg
);

   localparam int AW = $clog2(DRAM_WORDS);
   localparam int CW = $clog2(SCAN_DIV);

   logic [31:0]      mem_q [DRAM_WORDS];
   logic [AW-1:0]    word_idx;
   sel_e             sel;
   logic             addr_lo_unused;

   logic [31:0]      digits_q, digits_d;
   logic [23:0]      led_q, led_d;
   logic [23:0]      sw_meta_q, sw_sync_q;
   logic [CW-1:0]    scan_cnt_q, scan_cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             scan_wrap;
   logic [7:0]       seg_seg_q;
   logic [3:0]       cur_nib;
   logic [SEG_W-1:0] seg_pat;

   assign word_idx       = cpu_addr[AW+1:2];
   assign addr_lo_unused = ^cpu_addr[1:0];

   // Peripheral compares skip the byte-offset bits so any byte address in the word hits.
   always_comb begin
      sel = SEL_NONE;
      if (cpu_addr[31:AW+2] == '0)
         sel = SEL_DRAM;
      else if (cpu_addr[31:2] == DIGITS_ADDR[31:2])
         sel = SEL_DIGITS;
      else if (cpu_addr[31:2] == LED_ADDR[31:2])
         sel = SEL_LED;
      else if (cpu_addr[31:2] == SW_ADDR[31:2])
         sel = SEL_SW;
   end

   always_comb begin
      cpu_rdata = 32'h0;
      case (sel)
         SEL_DRAM:   cpu_rdata = mem_q[word_idx];
         SEL_DIGITS: cpu_rdata = digits_q;
         SEL_LED:    cpu_rdata = {8'h0, led_q};
         SEL_SW:     cpu_rdata = {8'h0, sw_sync_q};
         default:    cpu_rdata = 32'h0;
      endcase
   end

   // The array carries no reset so it maps onto block/distributed RAM.
   always_ff @(posedge clk) begin
      if (!rst && cpu_we && sel == SEL_DRAM)
         mem_q[word_idx] <= cpu_wdata;
   end

   always_comb begin
      digits_d = digits_q;
      led_d    = led_q;
      if (cpu_we) begin
         case (sel)
            SEL_DIGITS: digits_d = cpu_wdata;
            SEL_LED:    led_d    = cpu_wdata[23:0];
            default:    ;
         endcase
      end
      scan_wrap  = (scan_cnt_q == CW'(SCAN_DIV - 1));
      scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
      idx_d      = scan_wrap ? idx_q + 1'b1 : idx_q;
   end

   assign cur_nib = digits_q[{idx_q, 2'b00} +: 4];

   seg_decode u_seg_decode (
      .nib_i (cur_nib),
      .seg_o (seg_pat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         digits_q   <= '0;
         led_q      <= '0;
         sw_meta_q  <= '0;
         sw_sync_q  <= '0;
         scan_cnt_q <= '0;
         idx_q      <= '0;
         seg_seg_q  <= 8'hC0;
      end else begin
         digits_q   <= digits_d;
         led_q      <= led_d;
         sw_meta_q  <= sw;
         sw_sync_q  <= sw_meta_q;
         scan_cnt_q <= scan_cnt_d;
         idx_q      <= idx_d;
         seg_seg_q  <= {1'b1, seg_pat};
      end
   end

   assign led     = led_q;
   assign seg_en  = ~(8'(1) << idx_q);
   assign seg_seg = seg_seg_q;

endmodule

// File: tb/tb_dram_bridge.sv
// tb/tb_dram_bridge.sv - scoreboard bench for dram_bridge with directed vectors
module tb_dram_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_we;
   logic [31:0] cpu_rdata;
   logic [23:0] sw;
   logic [23:0] led;
   logic [7:0]  seg_en;
   logic [7:0]  seg_seg;

   dram_bridge #(.DRAM_WORDS(4096), .SCAN_DIV(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_we    (cpu_we),
      .cpu_rdata (cpu_rdata),
      .sw        (sw),
      .led       (led),
      .seg_en    (seg_en),
      .seg_seg   (seg_seg)
   );

   always #5 clk = ~clk;

   localparam int S_RDATA = 0;
   localparam int S_LED   = 1;
   localparam int S_SEGEN = 2;
   localparam int S_SEG   = 3;

   typedef struct {
      int          at;
      int          sel;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          n_vec = 0;
   int          n_miss = 0;
   logic [7:0]  seg_tbl [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void expect_v(int sel, logic [31:0] v, string name);
      exp_t e;
      e.at = cyc; e.sel = sel; e.exp = v; e.name = name;
      sb.push_back(e);
   endfunction

   exp_t        mon_e;
   logic [31:0] mon_got;

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].at <= cyc) begin
         mon_e = sb.pop_front();
         case (mon_e.sel)
            S_RDATA: mon_got = cpu_rdata;
            S_LED:   mon_got = {8'h0, led};
            S_SEGEN: mon_got = {24'h0, seg_en};
            default: mon_got = {24'h0, seg_seg};
         endcase
         n_vec++;
         if (mon_e.at != cyc) begin
            n_miss++;
            $display("FAIL %s: stale entry for cycle %0d seen at %0d", mon_e.name, mon_e.at, cyc);
         end else if (mon_got !== mon_e.exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", mon_e.name, mon_got, mon_e.exp, cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus(logic [31:0] a, logic we, logic [31:0] d);
      cpu_addr = a; cpu_we = we; cpu_wdata = d;
   endtask

   initial begin
      logic [7:0] onehot;
      rst = 1'b1; sw = '0;
      bus(32'h0, 1'b0, 32'h0);
      tick(); tick();
      bus(32'hFFFF_F070, 1'b0, 32'h0);
      expect_v(S_LED,   32'h0,  "reset_led");
      expect_v(S_SEGEN, 32'hFE, "reset_seg_en");
      expect_v(S_SEG,   32'hC0, "reset_seg_seg");
      expect_v(S_RDATA, 32'h0,  "reset_sw_read");
      tick();
      rst = 1'b0;

      // DRAM store/load, old value on same-cycle read, boundary words
      bus(32'h0000_0010, 1'b1, 32'h1111_1111); tick();
      bus(32'h0000_0010, 1'b1, 32'hDEAD_BEEF);
      expect_v(S_RDATA, 32'h1111_1111, "dram_old_word");
      tick();
      bus(32'h0000_0010, 1'b0, 32'h0);
      expect_v(S_RDATA, 32'hDEAD_BEEF, "dram_new_word");
      tick();
      bus(32'h0000_0000, 1'b1, 32'h55AA_55AA); tick();
      bus(32'h0000_3FFC, 1'b1, 32'h0BAD_F00D); tick();
      bus(32'h0000_3FFF, 1'b0, 32'h0);
      expect_v(S_RDATA, 32'h0BAD_F00D, "dram_last_word_byteoff");
      tick();

      // LED
      bus(32'hFFFF_F060, 1'b1, 32'h00A5_A5A5);
      expect_v(S_LED, 32'h0, "led_before_edge");
      tick();
      bus(32'hFFFF_F060, 1'b0, 32'h0);
      expect_v(S_LED,   32'h00A5_A5A5, "led_after_edge");
      expect_v(S_RDATA, 32'h00A5_A5A5, "led_read");
      tick();

      // switch synchronizer: two-edge lag, read-only
      bus(32'hFFFF_F070, 1'b0, 32'h0);
      sw = 24'h123456;
      expect_v(S_RDATA, 32'h0, "sw_lag0");
      tick();
      expect_v(S_RDATA, 32'h0, "sw_lag1");
      tick();
      expect_v(S_RDATA, 32'h0012_3456, "sw_synced");
      bus(32'hFFFF_F070, 1'b1, 32'hFFFF_FFFF);
      tick();
      bus(32'hFFFF_F070, 1'b0, 32'h0);
      expect_v(S_RDATA, 32'h0012_3456, "sw_write_ignored");
      tick();

      // unmapped, including first word past the DRAM window (would alias word 0)
      bus(32'h0001_0000, 1'b1, 32'hCAFE_F00D);
      expect_v(S_RDATA, 32'h0, "unmapped_read");
      tick();
      bus(32'h0000_4000, 1'b1, 32'h1234_5678);
      expect_v(S_RDATA, 32'h0, "dram_edge_unmapped_read");
      tick();
      bus(32'h0000_0000, 1'b0, 32'h0);
      expect_v(S_RDATA, 32'h55AA_55AA, "dram_word0_kept");
      expect_v(S_LED,   32'h00A5_A5A5, "led_kept");
      tick();
      bus(32'h0000_0010, 1'b0, 32'h0);
      expect_v(S_RDATA, 32'hDEAD_BEEF, "dram_word4_kept");
      tick();
      bus(32'hFFFF_F000, 1'b0, 32'h0);
      expect_v(S_RDATA, 32'h0, "digits_kept");
      tick();

      // digits nonzero, let scan run, then reset mid-scan with a colliding LED store
      bus(32'hFFFF_F000, 1'b1, 32'hFEDC_BA98); tick();
      bus(32'hFFFF_F000, 1'b0, 32'h0);
      repeat (6) tick();
      rst = 1'b1;
      bus(32'hFFFF_F060, 1'b1, 32'h00FF_FFFF);
      tick();
      expect_v(S_LED,   32'h0,  "rst_led_store_dropped");
      expect_v(S_SEGEN, 32'hFE, "rst_mid_seg_en");
      expect_v(S_SEG,   32'hC0, "rst_mid_seg_seg");
      rst = 1'b0;
      bus(32'hFFFF_F000, 1'b1, 32'h7654_3210);
      expect_v(S_RDATA, 32'h0, "rst_digits_cleared");
      tick();
      bus(32'hFFFF_F000, 1'b0, 32'h0);
      expect_v(S_RDATA, 32'h7654_3210, "digits_read");

      // k = edges since the reset edge; digit value equals its index
      for (int k = 1; k <= 40; k++) begin
         onehot = 8'h01 << ((k / 4) % 8);
         expect_v(S_SEGEN, {24'h0, ~onehot}, $sformatf("scan_en_k%0d", k));
         expect_v(S_SEG, {24'h0, seg_tbl[((k - 1) / 4) % 8]}, $sformatf("scan_seg_k%0d", k));
         tick();
      end

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      if (sb.size() > 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
